// File: rtl/hamming_pkg.sv
// -----------------------------------------------------------------------------
// hamming_pkg
// Shared definitions for the extended-Hamming (SECDED) codec:
//   MODE_ENC / MODE_DEC  - transaction mode encoding
//   DEF_DATA_W           - default data width
//   calc_r(data_w)       - number of Hamming parity bits R
//   calc_code_w(data_w)  - codeword width DATA_W + R + 1 (incl. overall parity)
//   is_pow2(idx)         - true for parity positions 1, 2, 4, ...
//   data_pos(j)          - codeword position of data bit j
// -----------------------------------------------------------------------------
package hamming_pkg;

    localparam logic MODE_ENC   = 1'b0;
    localparam logic MODE_DEC   = 1'b1;
    localparam int   DEF_DATA_W = 8;

    // Smallest r with 2^r >= data_w + r + 1.
    function automatic int calc_r(input int data_w);
        int r;
        r = 1;
        while ((1 << r) < data_w + r + 1) r++;
        return r;
    endfunction

    function automatic int calc_code_w(input int data_w);
        return data_w + calc_r(data_w) + 1;
    endfunction

    function automatic logic is_pow2(input int idx);
        return (idx > 0) && ((idx & (idx - 1)) == 0);
    endfunction

    // Data bits fill the non-power-of-two positions in ascending order.
    function automatic int data_pos(input int j);
        int pos;
        int cnt;
        pos = 0;
        cnt = 0;
        for (int p = 1; p < 128; p++) begin
            if (!is_pow2(p)) begin
                if (cnt == j && pos == 0) pos = p;
                cnt++;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/hamming_pipe_stage.sv
// -----------------------------------------------------------------------------
// hamming_pipe_stage
// Generic elastic valid/ready register slice.
//   clk, rst_n        - clock, async active-low reset (clears valid and data)
//   i_valid/o_ready   - upstream handshake, i_data payload in
//   o_valid/i_ready   - downstream handshake, o_data payload out
// The slice loads when empty or when its content leaves in the same cycle, so
// a chain of these runs at full rate. Data only changes on a load, which keeps
// the output stable while the consumer stalls.
// -----------------------------------------------------------------------------
module hamming_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;
    logic         w_load;

    assign o_ready = !r_valid || i_ready;
    assign w_load  = i_valid && o_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/hamming_secded_pipe.sv
// -----------------------------------------------------------------------------
// hamming_secded_pipe
// Two-stage pipelined extended-Hamming SECDED encoder/decoder.
//   clk, rst_n                 - clock, async active-low reset
//   in_valid/in_ready          - input handshake
//   in_mode                    - MODE_ENC (data in [DATA_W-1:0]) or MODE_DEC
//   in_word                    - data or received codeword
//   out_valid/out_ready        - output handshake
//   out_mode, out_word         - codeword (encode) or corrected data (decode)
//   out_syndrome               - decode syndrome, 0 for encode
//   out_single / out_double    - corrected / uncorrectable flags
//   cnt_clear                  - synchronous clear of both counters
//   corr_cnt / uncorr_cnt      - saturating counts of transferred decode results
// Codeword: bit 0 = overall parity, bit i = Hamming position i.
// -----------------------------------------------------------------------------
module hamming_secded_pipe
    import hamming_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int CNT_W  = 16,
    localparam int R      = calc_r(DATA_W),
    localparam int CODE_W = calc_code_w(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mode,
    input  logic [CODE_W-1:0] in_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_mode,
    output logic [CODE_W-1:0] out_word,
    output logic [R-1:0]      out_syndrome,
    output logic              out_single,
    output logic              out_double,
    input  logic              cnt_clear,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt
);

    localparam int IW   = $clog2(CODE_W);
    localparam int S1_W = 1 + CODE_W + R + 1;
    localparam int S2_W = 1 + CODE_W + R + 2;

    // ---------------- stage 1: syndrome / parity ----------------
    // Encode spreads data into a zero-parity word; the syndrome of that word is
    // exactly the parity-bit vector, so one syndrome tree serves both modes.
    logic [CODE_W-1:0] w_pre;
    logic [R-1:0]      w_syn;
    logic              w_par;

    always_comb begin
        w_pre = '0;
        if (in_mode == MODE_ENC) begin
            for (int j = 0; j < DATA_W; j++) w_pre[IW'(data_pos(j))] = in_word[j];
        end else begin
            w_pre = in_word;
        end
    end

    always_comb begin
        w_syn = '0;
        for (int i = 1; i < CODE_W; i++) begin
            if (w_pre[i]) w_syn = w_syn ^ R'(i);
        end
    end

    assign w_par = ^w_pre;

    logic [S1_W-1:0] w_s1_in, w_s1_out;
    logic            w_s1_valid, w_s2_ready;

    assign w_s1_in = {in_mode, w_pre, w_syn, w_par};

    hamming_pipe_stage #(.W(S1_W)) u_s1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_data  (w_s1_in),
        .o_valid (w_s1_valid),
        .i_ready (w_s2_ready),
        .o_data  (w_s1_out)
    );

    // ---------------- stage 2: correction / extraction ----------------
    logic              w1_mode, w1_par;
    logic [CODE_W-1:0] w1_word;
    logic [R-1:0]      w1_syn;

    assign {w1_mode, w1_word, w1_syn, w1_par} = w_s1_out;

    logic              w_in_range, w_single, w_double;
    logic [CODE_W-1:0] w_corr, w_res;
    logic [R-1:0]      w_res_syn;

    // Syndromes beyond the last position cannot come from a single flip.
    assign w_in_range = (w1_syn <= R'(CODE_W - 1));
    assign w_single   = (w1_mode == MODE_DEC) && w1_par && w_in_range;
    assign w_double   = (w1_mode == MODE_DEC) &&
                        (w1_par ? !w_in_range : (w1_syn != '0));
    assign w_res_syn  = (w1_mode == MODE_DEC) ? w1_syn : '0;

    always_comb begin
        w_corr = w1_word;
        for (int i = 0; i < CODE_W; i++) begin
            if (w_single && (w1_syn == R'(i))) w_corr[i] = !w1_word[i];
        end
    end

    always_comb begin
        w_res = '0;
        if (w1_mode == MODE_ENC) begin
            w_res = w1_word;
            for (int k = 0; k < R; k++) w_res[1 << k] = w1_syn[k];
            // data parity xor Hamming parity bits = parity of bits 1..CODE_W-1
            w_res[0] = w1_par ^ (^w1_syn);
        end else begin
            for (int j = 0; j < DATA_W; j++) w_res[j] = w_corr[IW'(data_pos(j))];
        end
    end

    logic [S2_W-1:0] w_s2_in, w_s2_out;

    assign w_s2_in = {w1_mode, w_res, w_res_syn, w_single, w_double};

    hamming_pipe_stage #(.W(S2_W)) u_s2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_s1_valid),
        .o_ready (w_s2_ready),
        .i_data  (w_s2_in),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (w_s2_out)
    );

    assign {out_mode, out_word, out_syndrome, out_single, out_double} = w_s2_out;

    // ---------------- error counters ----------------
    logic             w_dec_xfer;
    logic [CNT_W-1:0] r_corr, r_uncorr;

    assign w_dec_xfer = out_valid && out_ready && (out_mode == MODE_DEC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_corr   <= '0;
            r_uncorr <= '0;
        end else if (cnt_clear) begin
            r_corr   <= '0;
            r_uncorr <= '0;
        end else begin
            if (w_dec_xfer && out_single && !(&r_corr))
                r_corr <= r_corr + CNT_W'(1);
            if (w_dec_xfer && out_double && !(&r_uncorr))
                r_uncorr <= r_uncorr + CNT_W'(1);
        end
    end

    assign corr_cnt   = r_corr;
    assign uncorr_cnt = r_uncorr;

endmodule

// File: tb/tb_hamming_secded_pipe.sv
// Bench for hamming_secded_pipe with DATA_W=8 (R=4, CODE_W=13).
module tb_hamming_secded_pipe;

    localparam int DW      = 8;
    localparam int RW      = 4;
    localparam int CW      = 13;
    localparam int NW      = 16;
    localparam int NSTREAM = 100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_mode = 1'b0;
    logic [CW-1:0] in_word = '0;
    logic          out_ready = 1'b1;
    logic          cnt_clear = 1'b0;
    logic          in_ready, out_valid, out_mode, out_single, out_double;
    logic [CW-1:0] out_word;
    logic [RW-1:0] out_syndrome;
    logic [NW-1:0] corr_cnt, uncorr_cnt;

    hamming_secded_pipe #(.DATA_W(DW), .CNT_W(NW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_mode      (in_mode),
        .in_word      (in_word),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_mode     (out_mode),
        .out_word     (out_word),
        .out_syndrome (out_syndrome),
        .out_single   (out_single),
        .out_double   (out_double),
        .cnt_clear    (cnt_clear),
        .corr_cnt     (corr_cnt),
        .uncorr_cnt   (uncorr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          mode;
        logic [CW-1:0] word;
        logic [RW-1:0] syn;
        logic          single;
        logic          dbl;
    } res_t;

    typedef struct {
        logic          mode;
        logic [CW-1:0] word;
        res_t          exp;
    } vec_t;

    int n_pass = 0;
    int n_total = 0;
    int exp_corr = 0;
    int exp_uncorr = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic res_t dut_res();
        res_t r;
        r = {out_mode, out_word, out_syndrome, out_single, out_double};
        return r;
    endfunction

    function automatic int sat(input int v);
        return (v >= 'hFFFF) ? 'hFFFF : v + 1;
    endfunction

    // Reference: straight from the position/parity rules of extended Hamming.
    function automatic res_t model(input logic mode, input logic [CW-1:0] w);
        res_t          r;
        logic [CW-1:0] c;
        int            s;
        int            j;
        logic          par;
        r = '0;
        r.mode = mode;
        c = '0;
        s = 0;
        j = 0;
        if (mode == 1'b0) begin
            for (int p = 1; p < CW; p++)
                if ((p & (p - 1)) != 0) begin c[p] = w[j]; j++; end
            for (int p = 1; p < CW; p++) if (c[p]) s = s ^ p;
            for (int k = 0; k < RW; k++) c[1 << k] = s[k];
            c[0] = ^c;
            r.word = c;
        end else begin
            c = w;
            par = ^w;
            for (int p = 1; p < CW; p++) if (w[p]) s = s ^ p;
            r.syn = s[RW-1:0];
            if (par && s < CW) begin
                c[s] = ~c[s];
                r.single = 1'b1;
            end else if (par || s != 0) begin
                r.dbl = 1'b1;
            end
            for (int p = 1; p < CW; p++)
                if ((p & (p - 1)) != 0) begin r.word[j] = c[p]; j++; end
        end
        return r;
    endfunction

    function automatic logic [CW-1:0] gen_code(input logic [DW-1:0] d, input int nflip);
        res_t          e;
        logic [CW-1:0] c;
        e = model(1'b0, {{(CW-DW){1'b0}}, d});
        c = e.word;
        for (int f = 0; f < nflip; f++) c[$urandom_range(CW - 1, 0)] ^= 1'b1;
        return c;
    endfunction

    function automatic vec_t mk(input logic m, input logic [CW-1:0] w, input logic [CW-1:0] ew,
                                input logic [RW-1:0] es, input logic s1, input logic d2);
        vec_t v;
        v.mode = m;
        v.word = w;
        v.exp.mode = m;
        v.exp.word = ew;
        v.exp.syn = es;
        v.exp.single = s1;
        v.exp.dbl = d2;
        return v;
    endfunction

    // One isolated transaction with out_ready high; optional cnt_clear on the
    // cycle the result transfers.
    task automatic run_one(input logic m, input logic [CW-1:0] w, input res_t exp,
                           input string nm, input logic clr);
        in_valid = 1'b1;
        in_mode = m;
        in_word = w;
        #1;
        check({nm, "/in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        check({nm, "/early"}, out_valid, 0);
        tick();
        check({nm, "/valid"}, out_valid, 1);
        check({nm, "/res"}, dut_res(), exp);
        cnt_clear = clr;
        tick();
        cnt_clear = 1'b0;
    endtask

    initial begin
        vec_t tbl[$];
        res_t q[$];
        res_t e, last;
        bit   stalled, took;
        int   sent, got;

        // ---------------- reset ----------------
        #2 rst_n = 1'b0;
        #1;
        check("reset/outs", {out_valid, dut_res(), corr_cnt, uncorr_cnt}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("reset/in_ready", in_ready, 1);

        // ---------------- directed table ----------------
        tbl.push_back(mk(1'b0, 13'h00A5, 13'h144E, 4'd0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 13'h140E, 13'h00A5, 4'd6, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, 13'h144F, 13'h00A5, 4'd0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, 13'h1406, 13'h00A0, 4'd5, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 13'h144E, 13'h00A5, 4'd0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 13'h1FA5, 13'h144E, 4'd0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 13'h00FF, 13'h1EEE, 4'd0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 13'h0000, 13'h0000, 4'd0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 13'h0448, 13'h0025, 4'd15, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 13'h0EEE, 13'h00FF, 4'd12, 1'b1, 1'b0));

        foreach (tbl[i]) begin
            run_one(tbl[i].mode, tbl[i].word, tbl[i].exp, $sformatf("tbl%0d", i), 1'b0);
            if (tbl[i].exp.single) exp_corr = sat(exp_corr);
            if (tbl[i].exp.dbl) exp_uncorr = sat(exp_uncorr);
            check($sformatf("tbl%0d/corr", i), corr_cnt, exp_corr);
            check($sformatf("tbl%0d/uncorr", i), uncorr_cnt, exp_uncorr);
        end

        // ---------------- random stream with random stalls ----------------
        stalled = 0;
        took = 0;
        sent = 0;
        got = 0;
        last = '0;
        for (int cyc = 0; cyc < 3000 && got < NSTREAM; cyc++) begin
            if (stalled) check("stream/stall", {out_valid, dut_res()}, {1'b1, last});
            if (!in_valid || took) begin
                if (sent < NSTREAM) begin
                    in_valid = 1'b1;
                    in_mode = sent[0];
                    if (in_mode && $urandom_range(0, 4) == 0) in_word = CW'($urandom);
                    else if (in_mode) in_word = gen_code(DW'($urandom), $urandom_range(0, 2));
                    else in_word = CW'($urandom);
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            took = in_valid && in_ready;
            if (took) begin
                q.push_back(model(in_mode, in_word));
                sent++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("stream/extra", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("stream/order", dut_res(), e);
                    if (e.single) exp_corr = sat(exp_corr);
                    if (e.dbl) exp_uncorr = sat(exp_uncorr);
                end
                got++;
            end
            stalled = out_valid && !out_ready;
            last = dut_res();
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("stream/count", got, NSTREAM);
        check("stream/left", q.size(), 0);
        check("stream/corr", corr_cnt, exp_corr);
        check("stream/uncorr", uncorr_cnt, exp_uncorr);

        // ---------------- clear, saturation, clear-wins ----------------
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        check("clear/both", {corr_cnt, uncorr_cnt}, 0);

        in_valid = 1'b1;
        in_mode = 1'b1;
        in_word = 13'h1406;
        repeat (65535) tick();
        in_valid = 1'b0;
        repeat (3) tick();
        check("sat/preload", uncorr_cnt, 16'hFFFF);
        run_one(1'b1, 13'h1406, model(1'b1, 13'h1406), "sat/extra", 1'b0);
        check("sat/hold", uncorr_cnt, 16'hFFFF);
        check("sat/corr", corr_cnt, 0);
        run_one(1'b1, 13'h140E, model(1'b1, 13'h140E), "sat/single", 1'b0);
        check("sat/corr1", corr_cnt, 1);
        run_one(1'b1, 13'h1406, model(1'b1, 13'h1406), "clrwin", 1'b1);
        check("clrwin/cnts", {corr_cnt, uncorr_cnt}, 0);

        // ---------------- reset with both stages full ----------------
        run_one(1'b1, 13'h144F, model(1'b1, 13'h144F), "pre_rst", 1'b0);
        check("pre_rst/corr", corr_cnt, 1);
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_mode = 1'b0;
        in_word = 13'h0033;
        tick();
        in_word = 13'h005A;
        tick();
        in_valid = 1'b0;
        check("full/in_ready", in_ready, 0);
        check("full/out_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("midrst/outs", {out_valid, dut_res(), corr_cnt, uncorr_cnt}, 0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        check("midrst/in_ready", in_ready, 1);
        check("midrst/empty", out_valid, 0);
        run_one(1'b0, 13'h00A5, mk(1'b0, 13'h00A5, 13'h144E, 4'd0, 1'b0, 1'b0).exp, "post_rst", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hamming_secded_pipe.md
# hamming_secded_pipe

Parametrised, pipelined extended-Hamming (SECDED) codec. Each transaction either encodes DATA_W data bits into a CODE_W-bit codeword or decodes a codeword back to data, with single-error correction and double-error detection. Two register stages and valid/ready handshakes on both sides allow direct insertion into streaming datapaths between producers and memories or links. Saturating error counters support link-health monitoring.

## Interface
- DATA_W, 8 — data bits per word, 1..57.
- CNT_W, 16 — width of each error counter.
- Derived, not overridable: R = smallest r with 2^r ≥ DATA_W + r + 1; CODE_W = DATA_W + R + 1.
- clk  in  1  — rising-edge clock.
- rst_n  in  1  — asynchronous, active-low reset.
- in_valid  in  1  — input word present.
- in_ready  out  1  — block accepts input this cycle.
- in_mode  in  1  — 0 = encode, 1 = decode.
- in_word  in  CODE_W  — encode: data in [DATA_W-1:0], upper bits ignored; decode: received codeword.
- out_valid  out  1  — result present.
- out_ready  in  1  — consumer accepts result.
- out_mode  out  1  — mode of the transaction being presented.
- out_word  out  CODE_W  — encode: codeword; decode: corrected data in [DATA_W-1:0], upper bits 0.
- out_syndrome  out  R  — decode syndrome; 0 for encode.
- out_single  out  1  — decode: single error corrected.
- out_double  out  1  — decode: uncorrectable error.
- cnt_clear  in  1  — synchronous clear of both counters.
- corr_cnt  out  CNT_W  — count of corrected words, saturating.
- uncorr_cnt  out  CNT_W  — count of uncorrectable words, saturating.

## Operation
- Codeword layout: bit 0 = overall parity; bit i (1..CODE_W-1) = Hamming position i. Parity bits sit at positions 1, 2, 4, …, 2^(R-1); data bits d0..d(DATA_W-1) fill the remaining positions in ascending order.
- Parity bit p(2^k) = XOR of all positions with bit k of the index set. Bit 0 = XOR of bits 1..CODE_W-1 (even overall parity).
- Decode: syndrome s = XOR of indices of all set bits in 1..CODE_W-1; P = XOR of all CODE_W bits.
  - s=0, P=0: clean.
  - P=1, s ≤ CODE_W-1: flip bit s (s=0 means bit 0), out_single=1.
  - P=0, s≠0: out_double=1; data passed uncorrected.
  - P=1, s > CODE_W-1: out_double=1; data uncorrected.
- Stage 1 registers: mode, word, parity/syndrome, P. Stage 2 registers: correction, extraction, flags.
- Counters increment by one per decode result transferred (out_valid & out_ready) with the matching flag. Each holds at all-ones. cnt_clear wins over a simultaneous increment.

## Timing
- Latency: 2 cycles from input transfer to out_valid with no stall. Throughput: 1 word/cycle.
- Pipeline is elastic: a stage loads when it is empty or its content moves downstream in the same cycle. in_ready = !s1_valid | s1_advance, combinational from out_ready. No bubbles under continuous flow.
- While out_valid=1 & out_ready=0: all out_* outputs stay stable.
- Mode may change on every transaction; results leave in order.
- Reset (any time, including mid-stream): both stage valids 0, all out_* 0, counters 0. in_ready=1 one cycle after deassertion. In-flight words are discarded.

## Structure
- Package hamming_pkg:
  - functions calc_r(DATA_W) and is_pow2(idx);
  - function data_pos(j) giving the codeword position of data bit j;
  - localparam CODE_W formula;
  - mode encoding constants MODE_ENC and MODE_DEC.
- Sub-module hamming_pipe_stage: a generic valid/ready register slice of parametric payload width, instantiated twice. All coding logic stays in the top module.

## Test plan
- Encode 0xA5 (DATA_W=8) → out_word 0x144E after 2 cycles; out_single=0, out_double=0.
- Decode 0x140E (bit 6 flipped) → data 0xA5, out_syndrome 6, out_single=1, corr_cnt=1.
- Decode 0x144F (bit 0 flipped) → data 0xA5, syndrome 0, out_single=1. Decode 0x1406 (bits 3 and 6 flipped) → out_double=1, uncorr_cnt increments, corr_cnt unchanged.
- Back-to-back stream of 100 random words alternating modes, with out_ready toggled randomly → results in order, none lost or duplicated, outputs stable during stall cycles.
- Preload uncorr_cnt to 0xFFFF via 65535 double errors, then one more double error → counter stays 0xFFFF. Assert cnt_clear on the same cycle as an error → counter reads 0.
- Assert rst_n low with both stages full → out_valid=0 immediately, counters 0; the first post-reset word encodes correctly.
